// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_pkg
//  Description : Shared types and constants for the truth-table extractor.
//                Holds the sweep FSM state encoding, the vector/code sizes
//                and the vector-index to code-bit mapping helper.
//  Revision    : 1.0  initial release
// ============================================================================
package tt_pkg;

    localparam int N_IN   = 4;
    localparam int N_VEC  = 16;
    localparam int CODE_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    // Bit of the code that the sample for vector idx ends up in. The top
    // realises this with a left shift, so this is documentation of the
    // mapping as much as a usable helper.
    function automatic logic [3:0] idx_to_bitpos(input logic [3:0] idx);
        return 4'(N_VEC - 1) - idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : bit_sync2
//  Description : Two-flop synchronizer for a single asynchronous bit.
//  Ports       : clk    - sampling clock
//                rst_n  - asynchronous active-low reset (flops clear to 0)
//                i_d    - asynchronous input
//                o_q    - synchronized output (second flop)
//  Revision    : 1.0  initial release
// ============================================================================
module bit_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/truth_table_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_extractor
//  Description : Sweeps all 16 input vectors of a 4-input combinational gate,
//                waits SETTLE_CYCLES per vector, samples the gate output
//                through a 2-flop synchronizer and rebuilds the 16-bit
//                truth-table code (vector idx lands in code[15-idx]).
//  Ports       : clk, rst_n         - clock, async active-low reset
//                start, abort       - sweep control (abort wins)
//                in1..in4           - registered vector, in1 = MSB
//                out                - gate output (asynchronous)
//                busy, done         - sweep in progress / 1-cycle completion
//                code, match        - last code, code == EXPECT_CODE
//  Options     : TT_MAJORITY_VOTE_EN - 3-cycle sample with 2-of-3 majority
//  Revision    : 1.0  initial release
// ============================================================================
import tt_pkg::*;

module truth_table_extractor #(
    parameter int          SETTLE_CYCLES = 4,      // >= 3, sync eats 2
    parameter logic [15:0] EXPECT_CODE   = 16'h0643,
    parameter int          CNT_W         = 8       // SETTLE_CYCLES < 2**CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    input  logic        out,
    output logic        busy,
    output logic        done,
    output logic [15:0] code,
    output logic        match
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       c_IDX_LAST = 4'(N_VEC - 1);

    tt_state_e          r_state;
    logic [3:0]         r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_vec;
    logic [CODE_W-1:0]  r_sr;
    logic [CODE_W-1:0]  r_code;
    logic               r_match;
    logic               w_sync;
    logic               w_bit;

    bit_sync2 u_out_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (out),
        .o_q   (w_sync)
    );

`ifdef TT_MAJORITY_VOTE_EN
    logic [1:0] r_vote;   // vote cycle within SAMPLE: 0, 1, 2
    logic [1:0] r_v;      // first two votes

    // Third vote is taken live on the final SAMPLE cycle.
    assign w_bit = (r_v[0] & r_v[1]) | (r_v[0] & w_sync) | (r_v[1] & w_sync);
`else
    assign w_bit = w_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_sr    <= '0;
            r_code  <= '0;
            r_match <= 1'b0;
`ifdef TT_MAJORITY_VOTE_EN
            r_vote  <= '0;
            r_v     <= '0;
`endif
        end else if (abort && (r_state == DRIVE || r_state == SAMPLE)) begin
            // Drop the partial sweep; code/match keep the last full result.
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_sr    <= '0;
`ifdef TT_MAJORITY_VOTE_EN
            r_vote  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_vec <= '0;
                    if (start && !abort) begin
                        r_state <= DRIVE;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_sr    <= '0;
                    end
                end
                DRIVE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
`ifdef TT_MAJORITY_VOTE_EN
                    if (r_vote != 2'd2) begin
                        r_v[r_vote[0]] <= w_sync;
                        r_vote         <= r_vote + 2'd1;
                    end else begin
                        r_vote <= '0;
`endif
                        r_sr <= {r_sr[CODE_W-2:0], w_bit};
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_vec   <= r_idx + 4'd1;
                            r_cnt   <= '0;
                            r_state <= DRIVE;
                        end
`ifdef TT_MAJORITY_VOTE_EN
                    end
`endif
                end
                DONE: begin
                    r_code  <= r_sr;
                    r_match <= (r_sr == EXPECT_CODE);
                    r_idx   <= '0;
                    r_vec   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign {in1, in2, in3, in4} = r_vec;
    assign busy  = (r_state == DRIVE) || (r_state == SAMPLE);
    assign done  = (r_state == DONE);
    assign code  = r_code;
    assign match = r_match;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_extractor
//  Description : Directed bench for truth_table_extractor. A behavioural gate
//                model selectable per sweep drives out from in1..in4; expected
//                codes, latencies and control behaviour are hand-computed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_truth_table_extractor;

    localparam int          c_SETTLE = 4;
    localparam logic [15:0] c_EXP    = 16'h0643;
`ifdef TT_MAJORITY_VOTE_EN
    localparam int c_VEC_COST = c_SETTLE + 3;
    localparam bit c_GLITCH   = 1'b1;
`else
    localparam int c_VEC_COST = c_SETTLE + 1;
    localparam bit c_GLITCH   = 1'b0;
`endif
    localparam int c_LAT = 16 * c_VEC_COST + 1;   // 81 / 113

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in1, in2, in3, in4;
    logic        out;
    logic        busy, done, match;
    logic [15:0] code;
    logic [3:0]  vec;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   model    = 0;   // 0 ref 0x0643, 1 const0, 2 const1, 3 out=in4
    int   cyc      = 0;
    logic glitch   = 1'b0;

    always #5 clk = ~clk;

    truth_table_extractor #(
        .SETTLE_CYCLES (c_SETTLE),
        .EXPECT_CODE   (c_EXP),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .in4   (in4),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .code  (code),
        .match (match)
    );

    assign vec = {in1, in2, in3, in4};

    // Gate under characterization: true at idx 5, 6, 9, 14, 15 for model 0.
    always_comb begin
        out = 1'b0;
        case (model)
            0: out = ((vec == 4'd5) || (vec == 4'd6) || (vec == 4'd9) ||
                      (vec == 4'd14) || (vec == 4'd15)) ^ glitch;
            1: out = 1'b0;
            2: out = 1'b1;
            3: out = vec[0];
            default: out = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full sweep from IDLE; cyc is 1 in the cycle after the accepting edge.
    task automatic sweep(input int m, input logic [15:0] exp_code, input logic exp_match,
                         input bit chk_vec, input bit glitch_en);
        int vec_err;
        vec_err = 0;
        model   = m;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < c_LAT + 10) begin
            if (chk_vec && (vec !== 4'((cyc - 1) / c_VEC_COST))) vec_err++;
            // Present on out at edge 46: idx 6 second vote in the vote build.
            glitch = glitch_en && (cyc == 46);
            @(posedge clk); #1;
            cyc++;
        end
        glitch = 1'b0;
        chk("done_latency", cyc, c_LAT);
        if (chk_vec) chk("vec_stepping", vec_err, 0);
        @(posedge clk); #1;
        chk("code", code, exp_code);
        chk("match", match, exp_match);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int d1, d2, gap, dones;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", code, 16'h0000);
        chk("rst_match", match, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec", vec, 4'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        sweep(0, 16'h0643, 1'b1, 1'b0, c_GLITCH);
        sweep(1, 16'h0000, 1'b0, 1'b0, 1'b0);
        sweep(2, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        sweep(3, 16'h5555, 1'b0, 1'b1, 1'b0);
        sweep(0, 16'h0643, 1'b1, 1'b0, 1'b0);

        // Abort mid-sweep with a constant-1 gate: previous result must stay.
        model = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_vec", vec, 4'h0);
        chk("abort_done", done, 0);
        chk("abort_code", code, 16'h0643);
        chk("abort_match", match, 1);
        dones = 0;
        for (int i = 0; i < c_LAT + 10; i++) begin
            if (done || busy) dones++;
            @(posedge clk); #1;
        end
        chk("abort_no_restart", dones, 0);

        // start held high: back-to-back sweeps with one IDLE cycle between.
        model = 0;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 1; d1 = 0; d2 = 0; gap = 0;
        for (int i = 0; i < 2 * c_LAT + 10; i++) begin
            if (done) begin
                if (d1 == 0) d1 = cyc;
                else if (d2 == 0) d2 = cyc;
            end
            if (d1 != 0 && d2 == 0 && !busy && !done) gap++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("held_done1", d1, c_LAT);
        chk("held_done2", d2, 2 * c_LAT + 1);
        chk("held_idle_gap", gap, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("held_code", code, 16'h0643);

        // Reset mid-sweep: outputs clear without waiting for a clock edge.
        model = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_code", code, 16'h0000);
        chk("midrst_match", match, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_vec", vec, 4'h0);
        chk("midrst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        sweep(3, 16'h5555, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
